// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller and trap CSR unit for the RV32 pipeline.
// Holds mstatus/mie/mip/mtvec/mepc/mcause plus a 32-bit machine timer,
// arbitrates pending interrupts against pipeline stalls and issues a
// one-cycle trap request with the vector address.
module intr_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ext_irq_i,
    input  logic                  stall_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  mret_i,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [ADDR_WIDTH-1:0] csr_wdata_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [ADDR_WIDTH-1:0] csr_rdata_o,
    output logic                  interrupt_enable_o,
    output logic [ADDR_WIDTH-1:0] mtvec_addr_o,
    output logic [ADDR_WIDTH-1:0] mepc_o
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MTIMECMP = 12'h7C0;
    localparam logic [11:0] CSR_MTIME    = 12'h7C1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] CAUSE_EXT  = ADDR_WIDTH'(32'h8000_000B);
    localparam logic [ADDR_WIDTH-1:0] CAUSE_TIM  = ADDR_WIDTH'(32'h8000_0007);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t                state_q, state_n;
    logic                  irq_sync1, meip;
    logic                  mtip;
    logic [ADDR_WIDTH-1:0] mtime, mtimecmp;
    logic                  mst_mie, mst_mpie;
    logic                  mie_mtie, mie_meie;
    logic [ADDR_WIDTH-1:0] mtvec_q, mepc_q, mcause_q;
    logic                  irq_pulse_q;

    logic ext_pend, pending, trap_take;
    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtimecmp;
    logic [ADDR_WIDTH-1:0] trap_pc;

    assign ext_pend  = mie_meie & meip;
    assign pending   = mst_mie & (ext_pend | (mie_mtie & mtip));
    assign trap_take = (state_q == ST_TRAP);
    assign trap_pc   = jump_enable_i ? jump_addr_i : inst_addr_i;

    assign wr_mstatus  = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
    assign wr_mie      = csr_we_i && (csr_waddr_i == CSR_MIE);
    assign wr_mtvec    = csr_we_i && (csr_waddr_i == CSR_MTVEC);
    assign wr_mepc     = csr_we_i && (csr_waddr_i == CSR_MEPC);
    assign wr_mcause   = csr_we_i && (csr_waddr_i == CSR_MCAUSE);
    assign wr_mtimecmp = csr_we_i && (csr_waddr_i == CSR_MTIMECMP);

    assign interrupt_enable_o = irq_pulse_q;
    assign mtvec_addr_o       = mtvec_q;
    assign mepc_o             = mepc_q;

    // Trap arbitration: a pending interrupt waits out stalls, and is dropped if it goes away
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (pending && !mret_i) state_n = stall_i ? ST_WAIT : ST_TRAP;
            ST_WAIT: begin
                if (!pending)     state_n = ST_IDLE;
                else if (!stall_i) state_n = ST_TRAP;
            end
            ST_TRAP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; the trap request is a flop so the pipeline sees a clean pulse
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            irq_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            irq_pulse_q <= (state_n == ST_TRAP);
        end
    end

    // External line synchronizer, free-running timer and registered timer compare
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_sync1 <= 1'b0;
            meip      <= 1'b0;
            mtime     <= '0;
            mtip      <= 1'b0;
        end else begin
            irq_sync1 <= ext_irq_i;
            meip      <= irq_sync1;
            mtime     <= mtime + ADDR_WIDTH'(1);
            mtip      <= (mtime >= mtimecmp);
        end
    end

    // CSR state: trap entry outranks mret, which outranks a software write
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
            mie_mtie <= 1'b0;
            mie_meie <= 1'b0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtimecmp <= '1;
        end else begin
            if (trap_take) begin
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_i) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (wr_mstatus) begin
                mst_mie  <= csr_wdata_i[3];
                mst_mpie <= csr_wdata_i[7];
            end

            if (trap_take)    mepc_q <= trap_pc & ALIGN_MASK;
            else if (wr_mepc) mepc_q <= csr_wdata_i & ALIGN_MASK;

            if (trap_take)      mcause_q <= ext_pend ? CAUSE_EXT : CAUSE_TIM;
            else if (wr_mcause) mcause_q <= csr_wdata_i;

            if (wr_mie) begin
                mie_mtie <= csr_wdata_i[7];
                mie_meie <= csr_wdata_i[11];
            end
            if (wr_mtvec)    mtvec_q  <= csr_wdata_i & ALIGN_MASK;
            if (wr_mtimecmp) mtimecmp <= csr_wdata_i;
        end
    end

    // Combinational CSR read port; unmapped addresses read zero
    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[3] = mst_mie;
                csr_rdata_o[7] = mst_mpie;
            end
            CSR_MIE: begin
                csr_rdata_o[7]  = mie_mtie;
                csr_rdata_o[11] = mie_meie;
            end
            CSR_MTVEC:    csr_rdata_o = mtvec_q;
            CSR_MEPC:     csr_rdata_o = mepc_q;
            CSR_MCAUSE:   csr_rdata_o = mcause_q;
            CSR_MIP: begin
                csr_rdata_o[7]  = mtip;
                csr_rdata_o[11] = meip;
            end
            CSR_MTIMECMP: csr_rdata_o = mtimecmp;
            CSR_MTIME:    csr_rdata_o = mtime;
            default:      csr_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: randomized scenarios checked against
// expectations computed from the interrupt/trap rules with plain arithmetic.
module tb_intr_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MIP = 12'h344;
    localparam logic [11:0] A_MTIMECMP = 12'h7C0, A_MTIME = 12'h7C1;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ext_irq = 1'b0, stall = 1'b0, jump_en = 1'b0, mret = 1'b0, csr_we = 1'b0;
    logic [31:0] jump_addr = '0, inst_addr = '0, csr_wdata = '0, csr_rdata;
    logic [11:0] csr_waddr = '0, csr_raddr = '0;
    logic        irq_out;
    logic [31:0] mtvec_addr, mepc_out;

    int cyc = 0;
    int n_cmp = 0, n_bad = 0;

    intr_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ext_irq_i(ext_irq), .stall_i(stall),
        .jump_enable_i(jump_en), .jump_addr_i(jump_addr), .inst_addr_i(inst_addr),
        .mret_i(mret), .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata), .interrupt_enable_o(irq_out),
        .mtvec_addr_o(mtvec_addr), .mepc_o(mepc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference rules
    function automatic logic [31:0] align(input logic [31:0] v);
        return v & 32'hFFFF_FFFC;
    endfunction
    function automatic logic [31:0] exp_cause(input bit ext, input bit tim);
        return ext ? 32'h8000_000B : (tim ? 32'h8000_0007 : 32'h0);
    endfunction
    // pulse cycle for an external irq raised at c0 with stall released at rel
    function automatic int exp_ext_pulse(input int c0, input int rel);
        return (c0 + 3 > rel + 1) ? c0 + 3 : rel + 1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
        step();
        csr_we = 1'b0;
    endtask
    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_raddr = a; #1; d = csr_rdata;
    endtask
    task automatic wait_pulse(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (irq_out) begin at = cyc; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq_out); end
        n_cmp++; if (mtvec_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mtvec: got %h want 0", mtvec_addr); end
        n_cmp++; if (mepc_out !== 32'h0) begin n_bad++; $display("FAIL reset_mepc: got %h want 0", mepc_out); end
        csr_rd(A_MTIMECMP, r);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_mtimecmp: got %h want ffffffff", r); end
        csr_rd(A_MSTATUS, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_mstatus: got %h want 0", r); end
        csr_rd(A_MTIME, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_mtime: got %h want 0", r); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_csr_map();
        logic [31:0] r, v, m1;
        csr_wr(A_MTVEC, 32'h103);
        csr_rd(A_MTVEC, r);
        n_cmp++; if (r !== 32'h100) begin n_bad++; $display("FAIL mtvec_103_rd: got %h want 100", r); end
        n_cmp++; if (mtvec_addr !== 32'h100) begin n_bad++; $display("FAIL mtvec_103_out: got %h want 100", mtvec_addr); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            csr_wr(A_MTVEC, v);
            csr_wr(A_MCAUSE, v ^ 32'h5A5A_5A5A);
            csr_wr(A_MEPC, v + 32'd7);
            csr_rd(A_MTVEC, r);
            n_cmp++; if (r !== align(v)) begin n_bad++; $display("FAIL mtvec_rw: got %h want %h", r, align(v)); end
            csr_rd(A_MCAUSE, r);
            n_cmp++; if (r !== (v ^ 32'h5A5A_5A5A)) begin n_bad++; $display("FAIL mcause_rw: got %h want %h", r, v ^ 32'h5A5A_5A5A); end
            n_cmp++; if (mepc_out !== align(v + 32'd7)) begin n_bad++; $display("FAIL mepc_rw: got %h want %h", mepc_out, align(v + 32'd7)); end
            csr_wr(A_MTIMECMP, v);
            csr_rd(A_MTIMECMP, r);
            n_cmp++; if (r !== v) begin n_bad++; $display("FAIL mtimecmp_rw: got %h want %h", r, v); end
        end
        csr_wr(A_MTIMECMP, 32'hFFFF_FFFF);
        step();
        csr_wr(A_MIP, 32'hFFFF_FFFF);
        csr_wr(12'h123, 32'hFFFF_FFFF);
        csr_rd(A_MIP, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mip_ro: got %h want 0", r); end
        csr_rd(12'h123, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped: got %h want 0", r); end
        csr_wr(A_MIE, 32'hFFFF_FFFF);
        csr_wr(A_MSTATUS, 32'hFFFF_FFFF);
        csr_rd(A_MIE, r);
        n_cmp++; if (r !== 32'h880) begin n_bad++; $display("FAIL mie_bits: got %h want 880", r); end
        csr_rd(A_MSTATUS, r);
        n_cmp++; if (r !== 32'h88) begin n_bad++; $display("FAIL mstatus_bits: got %h want 88", r); end
        csr_rd(A_MTIME, m1);
        csr_wr(A_MTIME, 32'h0);
        csr_rd(A_MTIME, r);
        n_cmp++; if (r !== m1 + 32'd1) begin n_bad++; $display("FAIL mtime_ro: got %h want %h", r, m1 + 32'd1); end
        csr_wr(A_MSTATUS, 32'h0);
        csr_wr(A_MIE, 32'h0);
    endtask

    task automatic test_ext_irq();
        logic [31:0] r, mtv, ia;
        int c0, npulse;
        for (int it = 0; it < 4; it++) begin
            mtv = (it == 0) ? 32'h100 : $urandom;
            ia  = (it == 0) ? 32'h40 : $urandom;
            csr_wr(A_MTVEC, mtv);
            csr_wr(A_MIE, 32'h800);
            csr_wr(A_MSTATUS, 32'h8);
            inst_addr = ia;
            c0 = cyc; ext_irq = 1'b1;
            step(); step();
            n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL ext_early: got %b want 0 at +%0d", irq_out, cyc - c0); end
            csr_rd(A_MIP, r);
            n_cmp++; if (r !== 32'h800) begin n_bad++; $display("FAIL ext_meip: got %h want 800", r); end
            step();
            n_cmp++; if (irq_out !== 1'b1) begin n_bad++; $display("FAIL ext_pulse: got %b want 1 at +%0d", irq_out, cyc - c0); end
            n_cmp++; if (mtvec_addr !== align(mtv)) begin n_bad++; $display("FAIL ext_vector: got %h want %h", mtvec_addr, align(mtv)); end
            // software write landing on the trap cycle must lose
            case (it % 3)
                0: csr_wr(A_MEPC, ~ia);
                1: csr_wr(A_MSTATUS, 32'h8);
                default: csr_wr(A_MCAUSE, 32'h1234_5678);
            endcase
            n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL ext_width: got %b want 0", irq_out); end
            csr_rd(A_MEPC, r);
            n_cmp++; if (r !== align(ia)) begin n_bad++; $display("FAIL ext_mepc: got %h want %h", r, align(ia)); end
            csr_rd(A_MCAUSE, r);
            n_cmp++; if (r !== exp_cause(1, 0)) begin n_bad++; $display("FAIL ext_mcause: got %h want %h", r, exp_cause(1, 0)); end
            csr_rd(A_MSTATUS, r);
            n_cmp++; if (r !== 32'h80) begin n_bad++; $display("FAIL ext_mstatus: got %h want 80", r); end
            npulse = 0;
            repeat (6) begin step(); if (irq_out) npulse++; end
            n_cmp++; if (npulse !== 0) begin n_bad++; $display("FAIL ext_no_repeat: got %0d pulses want 0", npulse); end
            ext_irq = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic test_timer();
        logic [31:0] r, m;
        int d, ca, at;
        for (int it = 0; it < 3; it++) begin
            csr_wr(A_MSTATUS, 32'h0);
            csr_wr(A_MIE, 32'h0);
            d = $urandom_range(10, 25);
            csr_rd(A_MTIME, m);
            ca = cyc;
            csr_wr(A_MTIMECMP, m + d);
            csr_wr(A_MIE, 32'h80);
            csr_wr(A_MSTATUS, 32'h8);
            wait_pulse(40, at);
            // compare flag registers once mtime reaches cmp, trap follows one cycle later
            n_cmp++; if (at !== ca + d + 2) begin n_bad++; $display("FAIL timer_pulse_cycle: got %0d want %0d", at, ca + d + 2); end
            step();
            csr_rd(A_MCAUSE, r);
            n_cmp++; if (r !== exp_cause(0, 1)) begin n_bad++; $display("FAIL timer_mcause: got %h want %h", r, exp_cause(0, 1)); end
            csr_rd(A_MIP, r);
            n_cmp++; if (r !== 32'h80) begin n_bad++; $display("FAIL timer_mtip: got %h want 80", r); end
            csr_wr(A_MTIMECMP, 32'hFFFF_FFFF);
            step();
        end
        csr_wr(A_MIE, 32'h0);
    endtask

    task automatic test_both();
        logic [31:0] r;
        int w, at;
        csr_wr(A_MSTATUS, 32'h0);
        csr_wr(A_MIE, 32'h880);
        csr_wr(A_MTIMECMP, 32'h0);
        ext_irq = 1'b1;
        repeat (4) step();
        csr_rd(A_MIP, r);
        n_cmp++; if (r !== 32'h880) begin n_bad++; $display("FAIL both_mip: got %h want 880", r); end
        w = cyc;
        csr_wr(A_MSTATUS, 32'h8);
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL both_early: got %b want 0", irq_out); end
        wait_pulse(5, at);
        n_cmp++; if (at !== w + 2) begin n_bad++; $display("FAIL both_pulse_cycle: got %0d want %0d", at, w + 2); end
        step();
        csr_rd(A_MCAUSE, r);
        n_cmp++; if (r !== exp_cause(1, 1)) begin n_bad++; $display("FAIL both_mcause: got %h want %h", r, exp_cause(1, 1)); end
        ext_irq = 1'b0;
        csr_wr(A_MTIMECMP, 32'hFFFF_FFFF);
        csr_wr(A_MIE, 32'h0);
        repeat (3) step();
    endtask

    task automatic test_stall();
        logic [31:0] r, ia;
        int c0, len, at, exp;
        for (int it = 0; it < 5; it++) begin
            csr_wr(A_MIE, 32'h800);
            csr_wr(A_MSTATUS, 32'h8);
            ia = $urandom; inst_addr = ia;
            len = (it == 0) ? 5 : $urandom_range(0, 9);
            stall = 1'b1;
            c0 = cyc; ext_irq = 1'b1;
            exp = exp_ext_pulse(c0, c0 + len);
            at = -1;
            for (int k = 0; k < 20 && at < 0; k++) begin
                if (cyc == c0 + len) stall = 1'b0;
                step();
                if (irq_out) at = cyc;
            end
            stall = 1'b0;
            n_cmp++; if (at !== exp) begin n_bad++; $display("FAIL stall_pulse_cycle len=%0d: got %0d want %0d", len, at, exp); end
            step();
            csr_rd(A_MEPC, r);
            n_cmp++; if (r !== align(ia)) begin n_bad++; $display("FAIL stall_mepc: got %h want %h", r, align(ia)); end
            ext_irq = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic test_wait_drop();
        logic [31:0] r;
        int npulse, c1, at;
        csr_wr(A_MIE, 32'h800);
        csr_wr(A_MSTATUS, 32'h8);
        stall = 1'b1; ext_irq = 1'b1;
        npulse = 0;
        repeat (4) begin step(); if (irq_out) npulse++; end
        ext_irq = 1'b0;
        repeat (4) begin step(); if (irq_out) npulse++; end
        stall = 1'b0;
        repeat (8) begin step(); if (irq_out) npulse++; end
        n_cmp++; if (npulse !== 0) begin n_bad++; $display("FAIL drop_no_pulse: got %0d pulses want 0", npulse); end
        csr_rd(A_MSTATUS, r);
        n_cmp++; if (r !== 32'h8) begin n_bad++; $display("FAIL drop_mstatus: got %h want 8", r); end
        c1 = cyc; ext_irq = 1'b1;
        wait_pulse(10, at);
        n_cmp++; if (at !== c1 + 3) begin n_bad++; $display("FAIL drop_recover: got %0d want %0d", at, c1 + 3); end
        step();
        ext_irq = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_jump_mret();
        logic [31:0] r, ja;
        int c0, at;
        for (int it = 0; it < 2; it++) begin
            ja = (it == 0) ? 32'h200 : $urandom;
            inst_addr = $urandom;
            csr_wr(A_MIE, 32'h800);
            csr_wr(A_MSTATUS, 32'h8);
            jump_en = 1'b1; jump_addr = ja;
            c0 = cyc; ext_irq = 1'b1;
            wait_pulse(10, at);
            n_cmp++; if (at !== c0 + 3) begin n_bad++; $display("FAIL jump_pulse_cycle: got %0d want %0d", at, c0 + 3); end
            step();
            jump_en = 1'b0; ext_irq = 1'b0;
            csr_rd(A_MEPC, r);
            n_cmp++; if (r !== align(ja)) begin n_bad++; $display("FAIL jump_mepc: got %h want %h", r, align(ja)); end
            repeat (3) step();
            // mret together with a clearing mstatus write: mret must win
            mret = 1'b1;
            csr_wr(A_MSTATUS, 32'h0);
            mret = 1'b0;
            csr_rd(A_MSTATUS, r);
            n_cmp++; if (r !== 32'h88) begin n_bad++; $display("FAIL mret_mstatus: got %h want 88", r); end
            n_cmp++; if (mepc_out !== align(ja)) begin n_bad++; $display("FAIL mret_mepc_out: got %h want %h", mepc_out, align(ja)); end
            csr_wr(A_MSTATUS, 32'h0);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r;
        csr_wr(A_MTVEC, 32'h100);
        csr_wr(A_MIE, 32'h800);
        csr_wr(A_MSTATUS, 32'h8);
        csr_wr(A_MEPC, 32'h44);
        stall = 1'b1; ext_irq = 1'b1;
        repeat (5) step();
        rst_n = 1'b0; #1;
        n_cmp++; if (irq_out !== 1'b0 || mtvec_addr !== 32'h0 || mepc_out !== 32'h0) begin
            n_bad++; $display("FAIL rst_wait_outputs: got %b/%h/%h want 0/0/0", irq_out, mtvec_addr, mepc_out);
        end
        csr_rd(A_MTIMECMP, r);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_wait_mtimecmp: got %h want ffffffff", r); end
        csr_rd(A_MSTATUS, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rst_wait_mstatus: got %h want 0", r); end
        stall = 1'b0; ext_irq = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL rst_wait_after: got %b want 0", irq_out); end
    endtask

    initial begin
        test_reset();
        test_csr_map();
        test_ext_irq();
        test_timer();
        test_both();
        test_stall();
        test_wait_drop();
        test_jump_mret();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
